uart_rx: RTL and testbench

- UART receiver feeding the debug unit's command and instruction-load path; sits between the board RX pin and the debug unit's i_rx_data/i_rx_done inputs.
- Samples the line at 16x oversampling, deserialises 8N1 frames (LSB first) and pulses a one-cycle done strobe per valid byte.
- Rejects start-bit glitches, flags framing errors and suppresses delivery on them.
- Exports the shared baud tick for use by the transmitter.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

  localparam int unsigned NB_DATA_DEF  = 8;
  localparam int unsigned BAUD_DIV_DEF = 326;
  localparam int unsigned OVERSAMPLE   = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    START = 3'b001,
    DATA  = 3'b010,
    STOP  = 3'b011,
    BREAK = 3'b100
  } rx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running 16x oversampling tick generator
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling, glitch reject and break hold-off
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA  = NB_DATA_DEF,
  parameter int unsigned SB_TICK  = OVERSAMPLE,
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_frame_error,
  output logic               o_busy,
  output logic               o_tick
);

  localparam int unsigned SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int unsigned NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  logic               tick;
  logic               sync1_q, rx_s_q;
  rx_state_e          state_q;
  logic [SW-1:0]      s_q;
  logic [NW-1:0]      n_q;
  logic [NB_DATA-1:0] shift_q, data_q;
  logic               done_q, ferr_q;

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_tick  (tick)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            s_q     <= '0;
          end
        end
        // Start bit is re-checked at its centre so short low glitches fall back to IDLE.
        START: begin
          if (tick) begin
            if (s_q == SW'(7)) begin
              if (!rx_s_q) begin
                state_q <= DATA;
                s_q     <= '0;
                n_q     <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_q == SW'(OVERSAMPLE - 1)) begin
              s_q     <= '0;
              shift_q <= {rx_s_q, shift_q[NB_DATA-1:1]};
              if (n_q == NW'(NB_DATA - 1)) state_q <= STOP;
              else                         n_q     <= n_q + 1'b1;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s_q == SW'(SB_TICK - 1)) begin
              if (rx_s_q) begin
                state_q <= IDLE;
                data_q  <= shift_q;
                done_q  <= 1'b1;
              end else begin
                state_q <= BREAK;
                ferr_q  <= 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        // A held-low line parks here instead of producing a stream of 0x00 frames.
        BREAK: begin
          if (rx_s_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_rx_data     = data_q;
  assign o_rx_done     = done_q;
  assign o_frame_error = ferr_q;
  assign o_busy        = (state_q != IDLE);
  assign o_tick        = tick;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

  localparam int BD  = 4;
  localparam int BIT = BD * 16;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn, rst326, rx;
  logic [7:0] rx_data, d2_data;
  logic       done, ferr, busy, tick;
  logic       d2_done, d2_ferr, d2_busy, d2_tick;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  exp_t       exp_q[$];
  int         done_times[$];
  logic [7:0] model_data = 8'h00;
  int         last_tick4 = -1;
  int         last_tick326 = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.NB_DATA(8), .SB_TICK(16), .BAUD_DIV(BD)) dut (
    .i_clk         (clk),
    .i_reset       (rstn),
    .i_rx          (rx),
    .o_rx_data     (rx_data),
    .o_rx_done     (done),
    .o_frame_error (ferr),
    .o_busy        (busy),
    .o_tick        (tick)
  );

  uart_rx #(.NB_DATA(8), .SB_TICK(16), .BAUD_DIV(326)) dut326 (
    .i_clk         (clk),
    .i_reset       (rst326),
    .i_rx          (1'b1),
    .o_rx_data     (d2_data),
    .o_rx_done     (d2_done),
    .o_frame_error (d2_ferr),
    .o_busy        (d2_busy),
    .o_tick        (d2_tick)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference: a frame with stop=1 delivers its byte, stop=0 yields a framing error;
  // the pulse lands near the stop-bit centre, about 9.5 bit times after the start edge.
  always @(negedge clk) begin
    if (!rstn) begin
      model_data = 8'h00;
      exp_q.delete();
      last_tick4 = -1;
    end else begin
      if (done || ferr) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: got done=%0b ferr=%0b expected none at cycle %0d", done, ferr, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind", {30'd0, done, ferr}, e.err ? 32'd1 : 32'd2);
          chk_range("pulse_latency", cyc - e.t0, 600, 625);
          if (done) begin
            chk("rx_byte", {24'd0, rx_data}, {24'd0, e.data});
            model_data = e.data;
            done_times.push_back(cyc);
          end
        end
      end
      chk("data_hold", {24'd0, rx_data}, {24'd0, model_data});
      if (tick) begin
        if (last_tick4 >= 0) chk("tick4_period", cyc - last_tick4, BD);
        last_tick4 = cyc;
      end
    end
    if (!rst326) begin
      last_tick326 = -1;
    end else if (d2_tick) begin
      if (last_tick326 >= 0) chk("tick326_period", cyc - last_tick326, 326);
      last_tick326 = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_q.push_back('{err: !stop, data: d, t0: cyc});
    rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(BIT);
    end
    rx = stop;
    step(BIT);
  endtask

  task automatic idle_and_drain(input int bits);
    rx = 1'b1;
    step(bits * BIT);
    chk("queue_drained", exp_q.size(), 0);
    chk("busy_idle", {31'd0, busy}, 0);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rstn = 1'b0;
    rst326 = 1'b0;
    rx = 1'b1;
    step(5);
    @(negedge clk);
    chk("rst_data", {24'd0, rx_data}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ferr", {31'd0, ferr}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_tick", {31'd0, tick}, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    rst326 = 1'b1;
    step(2 * BIT);

    send_frame(8'hA5, 1'b1);
    idle_and_drain(2);
    chk("a5_literal", {24'd0, rx_data}, 32'hA5);
    chk("a5_one_done", done_times.size(), 1);

    done_times.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_and_drain(2);
    chk("b2b_count", done_times.size(), 2);
    if (done_times.size() == 2) chk_range("b2b_spacing", done_times[1] - done_times[0], 10 * BIT - BD, 10 * BIT + BD);
    chk("ff_literal", {24'd0, rx_data}, 32'hFF);

    rx = 1'b0;
    step(3 * BD);
    rx = 1'b1;
    step(60);
    chk("glitch_busy", {31'd0, busy}, 0);
    chk("glitch_data", {24'd0, rx_data}, 32'hFF);

    send_frame(8'h3C, 1'b0);
    step(20 * BIT);
    chk("break_busy", {31'd0, busy}, 1);
    idle_and_drain(2);
    chk("break_keeps_data", {24'd0, rx_data}, 32'hFF);
    send_frame(8'h12, 1'b1);
    idle_and_drain(2);
    chk("x12_literal", {24'd0, rx_data}, 32'h12);

    rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'h81 >> i);
      step(BIT);
    end
    rx = 1'b0;
    step(BIT / 2);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_data", {24'd0, rx_data}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_ferr", {31'd0, ferr}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_tick", {31'd0, tick}, 0);
    step(BIT / 2);
    for (int i = 5; i < 8; i++) begin
      rx = 1'(8'h81 >> i);
      step(BIT);
    end
    rx = 1'b1;
    step(BIT);
    rstn = 1'b1;
    idle_and_drain(2);
    send_frame(8'h81, 1'b1);
    idle_and_drain(2);
    chk("x81_literal", {24'd0, rx_data}, 32'h81);

    chk("d2_quiet", {d2_data, d2_done, d2_ferr, d2_busy}, 0);
    chk_range("tick326_seen", last_tick326, 1, cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
